// File: rtl/flappy_pixel_gen.sv
// Flappy-bird pixel generator: 2-stage colour pipeline plus a double-dabble score converter.
// Define FLAPPY_LEADING_ZERO_BLANK_EN to blank leading zero digits on the score screen.
//   state   | meaning
//   S_IDLE  | waiting for score to differ from the last converted value
//   S_SHIFT | one double-dabble add-3/shift step per cycle, SCORE_W cycles
//   S_DONE  | publish converted digits to the display array
module flappy_pixel_gen #(
  parameter int N_TUBES     = 3,
  parameter int TUBE_HALF_W = 30,
  parameter int GAP_HALF    = 50,
  parameter int BIRD_X      = 180,
  parameter int BIRD_HALF   = 15,
  parameter int SCORE_W     = 8,
  parameter int N_DIGITS    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   bright,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [9:0]             bird_y_pos,
  input  logic [10*N_TUBES-1:0]  tube_x_pos,
  input  logic [10*N_TUBES-1:0]  tube_y_pos,
  input  logic                   game_end,
  input  logic [SCORE_W-1:0]     score,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue,
  output logic                   bcd_busy
);
  localparam int BW = 4 * N_DIGITS;
  localparam int DW = BW + SCORE_W;
  localparam int CW = $clog2(SCORE_W + 1);
  localparam logic [10:0] TW = 11'(TUBE_HALF_W);
  localparam logic [10:0] GH = 11'(GAP_HALF);
  localparam logic [10:0] BX = 11'(BIRD_X);
  localparam logic [10:0] BH = 11'(BIRD_HALF);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_last, w_last_nxt;
  logic [DW-1:0]      r_dd, w_dd_nxt;
  logic [BW-1:0]      r_bcd, w_bcd_nxt, w_adj, w_blank;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [10:0]        w_x11, w_y11, w_by11;
  logic               w_bird_hit, w_tube_hit, w_digit_hit;
  logic               r_bird_hit, r_tube_hit, r_digit_hit, r_bright, r_game_end;
  logic [23:0]        w_rgb, r_rgb;

  function automatic logic in_box(input logic [15:0] px, py, x0, x1, y0, y1);
    return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
  endfunction

  // segment order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic seg_hit(input logic [6:0] s, input logic [15:0] px, py);
    return (s[0] && in_box(px, py, 16'd559, 16'd609, 16'd160, 16'd170)) ||
           (s[1] && in_box(px, py, 16'd614, 16'd624, 16'd160, 16'd237)) ||
           (s[2] && in_box(px, py, 16'd614, 16'd624, 16'd243, 16'd320)) ||
           (s[3] && in_box(px, py, 16'd559, 16'd609, 16'd310, 16'd320)) ||
           (s[4] && in_box(px, py, 16'd544, 16'd554, 16'd243, 16'd320)) ||
           (s[5] && in_box(px, py, 16'd544, 16'd554, 16'd160, 16'd237)) ||
           (s[6] && in_box(px, py, 16'd559, 16'd609, 16'd235, 16'd245));
  endfunction

  always_comb begin
    w_adj = r_dd[DW-1:SCORE_W];
    for (int k = 0; k < N_DIGITS; k++)
      if (w_adj[4*k+:4] >= 4'd5) w_adj[4*k+:4] = w_adj[4*k+:4] + 4'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_dd_nxt    = r_dd;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (score != r_last) begin
        w_state_nxt = S_SHIFT;
        w_last_nxt  = score;
        w_dd_nxt    = {{BW{1'b0}}, score};
        w_cnt_nxt   = CW'(SCORE_W - 1);
      end
      S_SHIFT: begin
        w_dd_nxt = {w_adj, r_dd[SCORE_W-1:0]} << 1;
        if (r_cnt == '0) w_state_nxt = S_DONE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_DONE: begin
        w_bcd_nxt   = r_dd[DW-1:SCORE_W];
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bcd_busy = (r_state != S_IDLE);

  // Lower bounds are written as "v + h >= c" in 11 bits so nothing wraps near zero.
  assign w_x11  = {1'b0, x};
  assign w_y11  = {1'b0, y};
  assign w_by11 = {1'b0, bird_y_pos};
  assign w_bird_hit = (w_x11 + BH >= BX) && (w_x11 <= BX + BH) &&
                      (w_y11 + BH >= w_by11) && (w_y11 <= w_by11 + BH);

  always_comb begin
    logic [10:0] tx, ty;
    w_tube_hit = 1'b0;
    for (int i = 0; i < N_TUBES; i++) begin
      tx = {1'b0, tube_x_pos[10*i+:10]};
      ty = {1'b0, tube_y_pos[10*i+:10]};
      if ((w_x11 + TW >= tx) && (w_x11 <= tx + TW) &&
          ((w_y11 >= ty + GH) || (w_y11 + GH <= ty)))
        w_tube_hit = 1'b1;
    end
  end

  always_comb begin
    logic hz;
    w_blank = '0;
    hz      = 1'b1;
`ifdef FLAPPY_LEADING_ZERO_BLANK_EN
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      hz         = hz && (r_bcd[4*k+:4] == 4'd0);
      w_blank[k] = hz;
    end
`else
    w_blank[0] = !hz;
`endif
  end

  always_comb begin
    logic [15:0] xk;
    w_digit_hit = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      xk = 16'(x) + 16'(120 * k);
      if (!w_blank[k] && seg_hit(seg7(r_bcd[4*k+:4]), xk, {6'd0, y}))
        w_digit_hit = 1'b1;
    end
  end

  always_comb begin
    w_rgb = 24'h000000;
    if (r_game_end)      w_rgb = r_digit_hit ? 24'hFFFFFF : 24'h000000;
    else if (r_bright) begin
      if (r_bird_hit)      w_rgb = 24'hFF0000;
      else if (r_tube_hit) w_rgb = 24'h00FF00;
      else                 w_rgb = 24'h0000FF;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_last      <= '0;
      r_dd        <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_bird_hit  <= 1'b0;
      r_tube_hit  <= 1'b0;
      r_digit_hit <= 1'b0;
      r_bright    <= 1'b0;
      r_game_end  <= 1'b0;
      r_rgb       <= 24'h000000;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_dd        <= w_dd_nxt;
      r_bcd       <= w_bcd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bird_hit  <= w_bird_hit;
      r_tube_hit  <= w_tube_hit;
      r_digit_hit <= w_digit_hit;
      r_bright    <= bright;
      r_game_end  <= game_end;
      r_rgb       <= w_rgb;
    end
  end

  assign red   = r_rgb[23:16];
  assign green = r_rgb[15:8];
  assign blue  = r_rgb[7:0];
endmodule
